// File: rtl/lr_car_detector.sv
// Local-road inductive-loop car detector: synchronizes and debounces the loop,
// tracks queued cars and latches a stuck-sensor fault that forces a fail-safe request.
module lr_car_detector #(
  parameter int DEB_CYC   = 4,
  parameter int STUCK_CYC = 64,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic [2:0]       lr_light,
  output logic             lr_has_car,
  output logic [CNT_W-1:0] car_count,
  output logic             sensor_fault,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PRESENT = 2'd1,
    FAULT   = 2'd2
  } loop_state_e;

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int OCC_W = $clog2(STUCK_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sync1_q, s_q;
  logic             det_q, det_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  loop_state_e      state_q, state_d;
  logic             arr_q, arr_d;
  logic             dep_q, dep_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             has_car_q, has_car_d;
  logic             fault_q, fault_d;
  logic             light_green, light_go;

  // Only the two legal one-hot codes count as green/yellow; everything else is red.
  assign light_green = (lr_light == 3'b100);
  assign light_go    = light_green || (lr_light == 3'b010);

  always_comb begin
    deb_d = deb_q;
    det_d = det_q;
    if (s_q == det_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
      deb_d = '0;
      det_d = ~det_q;
    end else begin
      deb_d = deb_q + DEB_W'(1);
    end
  end

  // Arrival/departure are registered one edge after the FSM sees det change,
  // so car_count moves two edges after det and lr_has_car one edge later.
  always_comb begin
    state_d = state_q;
    occ_d   = '0;
    arr_d   = 1'b0;
    dep_d   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (det_q) begin
          state_d = PRESENT;
          arr_d   = 1'b1;
        end
      end
      PRESENT: begin
        if (!det_q) begin
          state_d = EMPTY;
          dep_d   = light_go;
        end
      end
      FAULT: ;
      default: state_d = EMPTY;
    endcase
    if (state_q != FAULT && det_q && light_green) begin
      if (occ_q == OCC_W'(STUCK_CYC - 1)) begin
        state_d = FAULT;
      end else begin
        occ_d = occ_q + OCC_W'(1);
      end
    end
    fault_d = (state_d == FAULT);
  end

  always_comb begin
    count_d = count_q;
    if (state_q != FAULT) begin
      if (arr_q && count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end else if (dep_q && count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    has_car_d = (count_q != '0) || fault_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      det_q     <= 1'b0;
      deb_q     <= '0;
      occ_q     <= '0;
      state_q   <= EMPTY;
      arr_q     <= 1'b0;
      dep_q     <= 1'b0;
      count_q   <= '0;
      has_car_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= loop_raw;
      s_q       <= sync1_q;
      det_q     <= det_d;
      deb_q     <= deb_d;
      occ_q     <= occ_d;
      state_q   <= state_d;
      arr_q     <= arr_d;
      dep_q     <= dep_d;
      count_q   <= count_d;
      has_car_q <= has_car_d;
      fault_q   <= fault_d;
    end
  end

  assign lr_has_car   = has_car_q;
  assign car_count    = count_q;
  assign sensor_fault = fault_q;
  assign dbg_state_o  = state_q;

endmodule
